// File: rtl/mio_bus_gen.sv
// mio_bus_gen: memory-mapped I/O bus between the CPU and the game peripherals.
// addr_bus[31:28] selects RAM (0), LFSR random source (C), keyboard (D) or board cells (F).
// Reads are registered: data appears with rd_valid on the edge after the request.
// Build option: define MIO_BUS_KBFIFO_EN for a KB_DEPTH-entry keyboard scancode FIFO;
// without it the keyboard path is a single holding register.
module mio_bus_gen #(
    parameter int                N_CELLS  = 16,
    parameter int                CELL_W   = 4,
    parameter int                RAM_AW   = 10,
    parameter int                KB_DEPTH = 8,
    parameter int                RAND_W   = 16,
    parameter logic [RAND_W-1:0] RAND_TAP = 16'hB400,
    parameter logic [RAND_W-1:0] SEED     = 16'hACE1,
    parameter int                IDX_W    = $clog2(N_CELLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_req,
    input  logic              mem_w,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       Cpu_data2bus,
    output logic [31:0]       Cpu_data4bus,
    output logic              rd_valid,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data_in,
    output logic              data_ram_we,
    input  logic [31:0]       ram_data_out,
    input  logic [9:0]        ps2kb_key,
    input  logic              ps2kb_valid,
    input  logic [IDX_W-1:0]  cell_idx,
    output logic [CELL_W-1:0] cell_data
);

    localparam logic [3:0] REG_RAM  = 4'h0;
    localparam logic [3:0] REG_RAND = 4'hC;
    localparam logic [3:0] REG_KBD  = 4'hD;
    localparam logic [3:0] REG_CELL = 4'hF;

    logic             rd, wr;
    logic [3:0]       region;
    logic [31:0]      word_idx;
    logic             cell_hit;
    logic [IDX_W-1:0] cell_widx;
    logic             unused_addr_lsbs;

    assign rd        = bus_req & ~mem_w;
    assign wr        = bus_req & mem_w;
    assign region    = addr_bus[31:28];
    // The full word offset is compared so addresses past the last cell never alias onto low cells.
    assign word_idx  = {6'b0, addr_bus[27:2]};
    assign cell_hit  = (region == REG_CELL) && (word_idx < 32'(N_CELLS));
    assign cell_widx = word_idx[IDX_W-1:0];
    assign unused_addr_lsbs = ^addr_bus[1:0];

    assign ram_addr    = addr_bus[RAM_AW+1:2];
    assign ram_data_in = Cpu_data2bus;
    assign data_ram_we = wr && (region == REG_RAM);

    // ---------------- board cells ----------------
    logic [CELL_W-1:0] cells_q [N_CELLS];
    logic [CELL_W-1:0] cells_d [N_CELLS];
    logic [31:0]       disp_idx;

    // Board next state: at most one cell written per CPU write.
    always_comb begin
        // NOTE: blocking '=' in always_comb, with every output defaulted first, keeps this purely combinational (no latch).
        cells_d = cells_q;
        if (wr && cell_hit) cells_d[cell_widx] = Cpu_data2bus[CELL_W-1:0];
    end

    // Board register file.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the cell array is reset because the display reads it directly; keyboard FIFO storage is
        // deliberately not reset, since only occupied entries are ever returned.
        if (!rst_n) begin
            for (int i = 0; i < N_CELLS; i++) cells_q[i] <= '0;
        end else begin
            cells_q <= cells_d;
        end
    end

    assign disp_idx  = 32'(cell_idx);
    assign cell_data = (disp_idx < 32'(N_CELLS)) ? cells_q[cell_idx] : '0;

    // ---------------- LFSR random source ----------------
    logic [RAND_W-1:0] lfsr_q, lfsr_d;

    // Galois step every cycle; a CPU write reseeds instead, mapping zero to SEED so the LFSR never locks up.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[RAND_W-1:1]} ^ (lfsr_q[0] ? RAND_TAP : '0);
        if (wr && region == REG_RAND)
            lfsr_d = (Cpu_data2bus[RAND_W-1:0] == '0) ? SEED : Cpu_data2bus[RAND_W-1:0];
    end

    // LFSR state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    // ---------------- keyboard ----------------
    logic       kb_rd_data, kb_rd_stat;
    logic       kb_empty, kb_pop, kb_ovf_set;
    logic [9:0] kb_head;
    logic [7:0] kb_cnt8;
    logic       kb_ovf_q, kb_ovf_d;

    assign kb_rd_data = rd && (region == REG_KBD) && !addr_bus[2];
    assign kb_rd_stat = rd && (region == REG_KBD) &&  addr_bus[2];

`ifdef MIO_BUS_KBFIFO_EN
    localparam int KB_PW = $clog2(KB_DEPTH);
    localparam int KB_CW = $clog2(KB_DEPTH + 1);

    logic [9:0]       kb_mem_q [KB_DEPTH];
    logic [9:0]       kb_mem_d [KB_DEPTH];
    logic [KB_PW-1:0] kb_wp_q, kb_wp_d, kb_rp_q, kb_rp_d;
    logic [KB_CW-1:0] kb_cnt_q, kb_cnt_d;
    logic             kb_full, kb_push;

    assign kb_empty   = (kb_cnt_q == '0);
    assign kb_full    = (kb_cnt_q == KB_CW'(KB_DEPTH));
    assign kb_pop     = kb_rd_data && !kb_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the new key.
    assign kb_push    = ps2kb_valid && (!kb_full || kb_pop);
    assign kb_ovf_set = ps2kb_valid && kb_full && !kb_pop;
    assign kb_head    = kb_mem_q[kb_rp_q];
    assign kb_cnt8    = 8'(kb_cnt_q);

    // FIFO pointers, occupancy and storage next state; pointers wrap naturally at KB_DEPTH.
    always_comb begin
        kb_mem_d = kb_mem_q;
        kb_wp_d  = kb_wp_q;
        kb_rp_d  = kb_rp_q;
        kb_cnt_d = kb_cnt_q;
        if (kb_push) begin
            kb_mem_d[kb_wp_q] = ps2kb_key;
            kb_wp_d           = kb_wp_q + 1'b1;
        end
        if (kb_pop) kb_rp_d = kb_rp_q + 1'b1;
        case ({kb_push, kb_pop})
            2'b10:   kb_cnt_d = kb_cnt_q + 1'b1;
            2'b01:   kb_cnt_d = kb_cnt_q - 1'b1;
            default: kb_cnt_d = kb_cnt_q;
        endcase
    end

    // FIFO control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_wp_q  <= '0;
            kb_rp_q  <= '0;
            kb_cnt_q <= '0;
        end else begin
            kb_wp_q  <= kb_wp_d;
            kb_rp_q  <= kb_rp_d;
            kb_cnt_q <= kb_cnt_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        kb_mem_q <= kb_mem_d;
    end
`else
    logic [9:0] kb_key_q, kb_key_d;
    logic       kb_full_q, kb_full_d;
    logic       unused_kb_depth;

    assign unused_kb_depth = (KB_DEPTH > 0);
    assign kb_empty   = !kb_full_q;
    assign kb_pop     = kb_rd_data && kb_full_q;
    assign kb_ovf_set = ps2kb_valid && kb_full_q && !kb_pop;
    assign kb_head    = kb_key_q;
    assign kb_cnt8    = {7'b0, kb_full_q};

    // Holding register: a new key always lands (overwriting if unread); a DATA read empties it.
    always_comb begin
        kb_key_d  = kb_key_q;
        kb_full_d = kb_full_q;
        if (ps2kb_valid) begin
            kb_key_d  = ps2kb_key;
            kb_full_d = 1'b1;
        end else if (kb_pop) begin
            kb_full_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_key_q  <= '0;
            kb_full_q <= 1'b0;
        end else begin
            kb_key_q  <= kb_key_d;
            kb_full_q <= kb_full_d;
        end
    end
`endif

    // Sticky overflow: a STATUS read clears it, but a new overflow on the same edge wins.
    always_comb begin
        kb_ovf_d = kb_ovf_set | (kb_ovf_q & ~kb_rd_stat);
    end

    // Overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) kb_ovf_q <= 1'b0;
        else        kb_ovf_q <= kb_ovf_d;
    end

    // ---------------- read data path ----------------
    logic [31:0] bus_rdata;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q;

    // Read mux; unmapped regions and out-of-range cells read as zero.
    always_comb begin
        bus_rdata = '0;
        case (region)
            REG_RAM:  bus_rdata = ram_data_out;
            REG_RAND: bus_rdata = 32'(lfsr_q);
            REG_KBD: begin
                if (addr_bus[2])   bus_rdata = {kb_ovf_q | kb_ovf_set, 23'b0, kb_cnt8};
                else if (kb_empty) bus_rdata = 32'h8000_0000;
                else               bus_rdata = {1'b0, 21'b0, kb_head};
            end
            REG_CELL: if (cell_hit) bus_rdata = 32'(cells_q[cell_widx]);
            default:  bus_rdata = '0;
        endcase
        rd_data_d = rd ? bus_rdata : rd_data_q;
    end

    // Registered read data; holds its last value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd;
        end
    end

    assign Cpu_data4bus = rd_data_q;
    assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_mio_bus_gen.sv
// tb_mio_bus_gen: directed test of mio_bus_gen against a queue/array reference model,
// checked every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_mio_bus_gen;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAP  = 16'hB400;
`ifdef MIO_BUS_KBFIFO_EN
    localparam int KB_CAP = 8;
`else
    localparam int KB_CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] addr_bus = '0;
    logic [31:0] Cpu_data2bus = '0;
    logic [31:0] Cpu_data4bus;
    logic        rd_valid;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data_in;
    logic        data_ram_we;
    logic [31:0] ram_data_out;
    logic [9:0]  ps2kb_key = '0;
    logic        ps2kb_valid = 1'b0;
    logic [3:0]  cell_idx = '0;
    logic [3:0]  cell_data;

    int n_pass  = 0;
    int n_total = 0;

    mio_bus_gen dut (
        .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .mem_w(mem_w),
        .addr_bus(addr_bus), .Cpu_data2bus(Cpu_data2bus), .Cpu_data4bus(Cpu_data4bus),
        .rd_valid(rd_valid), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .data_ram_we(data_ram_we), .ram_data_out(ram_data_out),
        .ps2kb_key(ps2kb_key), .ps2kb_valid(ps2kb_valid),
        .cell_idx(cell_idx), .cell_data(cell_data)
    );

    always #5 clk = ~clk;

    // External data RAM: unwritten words read as a recognisable address pattern.
    bit [31:0] tb_ram [1024];
    bit        tb_written [1024];
    always @(posedge clk) begin
        if (data_ram_we) begin
            tb_ram[ram_addr]     <= ram_data_in;
            tb_written[ram_addr] <= 1'b1;
        end
    end
    assign ram_data_out = tb_written[ram_addr] ? tb_ram[ram_addr] : (32'hC0DE_0000 | 32'(ram_addr));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? TAP : 16'h0);
    endfunction

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    logic [3:0]  m_cells [16];
    logic [9:0]  m_kq [$];
    bit          m_ovf;
    logic [31:0] m_ram [int];
    logic        exp_valid;
    logic [31:0] exp_data;

    always @(posedge clk or negedge rst_n) begin : model
        logic        rd, wr, pop, stat, ovf_set;
        logic [3:0]  region;
        int          widx, ridx;
        logic [31:0] val;
        if (!rst_n) begin
            m_lfsr = SEED;
            foreach (m_cells[i]) m_cells[i] = '0;
            m_kq.delete();
            m_ovf     = 1'b0;
            exp_valid = 1'b0;
            exp_data  = '0;
        end else begin
            rd      = bus_req && !mem_w;
            wr      = bus_req && mem_w;
            region  = addr_bus[31:28];
            widx    = int'(addr_bus[27:2]);
            ridx    = widx % 1024;
            pop     = rd && region == 4'hD && !addr_bus[2] && m_kq.size() > 0;
            stat    = rd && region == 4'hD && addr_bus[2];
            ovf_set = ps2kb_valid && m_kq.size() == KB_CAP && !pop;
            case (region)
                4'h0: val = m_ram.exists(ridx) ? m_ram[ridx] : (32'hC0DE_0000 | 32'(ridx));
                4'hC: val = {16'h0, m_lfsr};
                4'hD: begin
                    if (addr_bus[2])         val = {m_ovf | ovf_set, 23'h0, 8'(m_kq.size())};
                    else if (m_kq.size() == 0) val = 32'h8000_0000;
                    else                     val = {22'h0, m_kq[0]};
                end
                4'hF:    val = (widx < 16) ? {28'h0, m_cells[widx]} : 32'h0;
                default: val = 32'h0;
            endcase
            exp_valid = rd;
            if (rd) exp_data = val;
            if (wr && region == 4'h0) m_ram[ridx] = Cpu_data2bus;
            if (wr && region == 4'hF && widx < 16) m_cells[widx] = Cpu_data2bus[3:0];
            if (wr && region == 4'hC) m_lfsr = (Cpu_data2bus[15:0] != 0) ? Cpu_data2bus[15:0] : SEED;
            else                      m_lfsr = lfsr_next(m_lfsr);
            if (pop) void'(m_kq.pop_front());
            if (ps2kb_valid) begin
                if (m_kq.size() < KB_CAP) m_kq.push_back(ps2kb_key);
                else if (KB_CAP == 1)     m_kq[0] = ps2kb_key;
            end
            if (ovf_set)   m_ovf = 1'b1;
            else if (stat) m_ovf = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_valid", {31'b0, rd_valid}, {31'b0, exp_valid});
            check("rd_data", Cpu_data4bus, exp_data);
            check("cell_data", {28'b0, cell_data}, {28'b0, m_cells[cell_idx]});
            check("ram_we", {31'b0, data_ram_we}, {31'b0, bus_req && mem_w && addr_bus[31:28] == 4'h0});
            check("ram_addr", {22'b0, ram_addr}, {22'b0, addr_bus[11:2]});
            check("ram_wdata", ram_data_in, Cpu_data2bus);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic kv, input logic [9:0] key);
        bus_req = req; mem_w = we; addr_bus = addr; Cpu_data2bus = wd;
        ps2kb_valid = kv; ps2kb_key = key;
        @(posedge clk); #1;
        bus_req = 1'b0; mem_w = 1'b0; ps2kb_valid = 1'b0;
    endtask

    task automatic idle();                                          tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 10'h0); endtask
    task automatic rd(input logic [31:0] a);                        tick(1'b1, 1'b0, a, 32'h0, 1'b0, 10'h0);    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);  tick(1'b1, 1'b1, a, d, 1'b0, 10'h0);        endtask
    task automatic push(input logic [9:0] k);                       tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, k);     endtask
    task automatic rd_chk(input string n, input logic [31:0] a, input logic [31:0] e);
        rd(a);
        check(n, Cpu_data4bus, e);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_valid", {31'b0, rd_valid}, 32'h0);
        check("reset rd_data", Cpu_data4bus, 32'h0);
        check("reset cell0", {28'b0, cell_data}, 32'h0);
        rst_n = 1'b1;

        // LFSR one step after reset: 0xACE1 >> 1 = 0x5670, lsb was 1 so ^ 0xB400 = 0xE270.
        idle();
        rd_chk("rand first", 32'hC000_0000, 32'h0000_E270);
        check("rand rd_valid", {31'b0, rd_valid}, 32'h1);
        idle();
        check("rd_valid drops", {31'b0, rd_valid}, 32'h0);

        // Board cells, including the last cell and an out-of-range index.
        wr(32'hF000_000C, 32'h0000_0007);
        rd_chk("cell3 read", 32'hF000_000C, 32'h0000_0007);
        cell_idx = 4'd3;
        #1;
        check("cell3 display", {28'b0, cell_data}, 32'h0000_0007);
        wr(32'hF000_0040, 32'h0000_0005);
        rd_chk("cell16 read", 32'hF000_0040, 32'h0);
        rd_chk("cell0 no alias", 32'hF000_0000, 32'h0);
        wr(32'hF000_003C, 32'h0000_00FA);
        rd_chk("cell15 read", 32'hF000_003C, 32'h0000_000A);
        rd_chk("unmapped read", 32'h5000_0000, 32'h0);

`ifdef MIO_BUS_KBFIFO_EN
        push(10'h01C);
        push(10'h01D);
        rd_chk("kb pop1", 32'hD000_0000, 32'h0000_001C);
        rd_chk("kb pop2", 32'hD000_0000, 32'h0000_001D);
        rd_chk("kb empty", 32'hD000_0000, 32'h8000_0000);
        for (int i = 0; i < 9; i++) push(10'(10'h100 + i));
        rd_chk("kb ovf status", 32'hD000_0004, 32'h8000_0008);
        rd_chk("kb ovf cleared", 32'hD000_0004, 32'h0000_0008);
        tick(1'b1, 1'b0, 32'hD000_0000, 32'h0, 1'b1, 10'h1FF);
        check("kb full push+pop", Cpu_data4bus, 32'h0000_0100);
        rd_chk("kb count kept", 32'hD000_0004, 32'h0000_0008);
        tick(1'b1, 1'b0, 32'hD000_0004, 32'h0, 1'b1, 10'h155);
        check("kb ovf set+read", Cpu_data4bus, 32'h8000_0008);
        rd_chk("kb ovf set wins", 32'hD000_0004, 32'h8000_0008);
        rd_chk("kb ovf clear2", 32'hD000_0004, 32'h0000_0008);
        for (int i = 0; i < 8; i++)
            rd_chk("kb drain", 32'hD000_0000, (i < 7) ? 32'(32'h101 + i) : 32'h0000_01FF);
        rd_chk("kb drained", 32'hD000_0000, 32'h8000_0000);
        tick(1'b1, 1'b0, 32'hD000_0000, 32'h0, 1'b1, 10'h077);
        check("kb empty push+pop", Cpu_data4bus, 32'h8000_0000);
        rd_chk("kb count one", 32'hD000_0004, 32'h0000_0001);
        rd_chk("kb no bypass key", 32'hD000_0000, 32'h0000_0077);
`else
        push(10'h01C);
        rd_chk("kb read", 32'hD000_0000, 32'h0000_001C);
        rd_chk("kb empty", 32'hD000_0000, 32'h8000_0000);
        push(10'h01C);
        push(10'h01D);
        rd_chk("kb ovf status", 32'hD000_0004, 32'h8000_0001);
        rd_chk("kb ovf cleared", 32'hD000_0004, 32'h0000_0001);
        rd_chk("kb overwritten", 32'hD000_0000, 32'h0000_001D);
        push(10'h02A);
        tick(1'b1, 1'b0, 32'hD000_0000, 32'h0, 1'b1, 10'h02B);
        check("kb push+read old", Cpu_data4bus, 32'h0000_002A);
        rd_chk("kb no ovf", 32'hD000_0004, 32'h0000_0001);
        rd_chk("kb new kept", 32'hD000_0000, 32'h0000_002B);
        tick(1'b1, 1'b0, 32'hD000_0000, 32'h0, 1'b1, 10'h033);
        check("kb empty push+read", Cpu_data4bus, 32'h8000_0000);
        rd_chk("kb no bypass key", 32'hD000_0000, 32'h0000_0033);
        push(10'h044);
        tick(1'b1, 1'b0, 32'hD000_0004, 32'h0, 1'b1, 10'h045);
        check("kb ovf set+read", Cpu_data4bus, 32'h8000_0001);
        rd_chk("kb ovf set wins", 32'hD000_0004, 32'h8000_0001);
        rd_chk("kb ovf clear2", 32'hD000_0004, 32'h0000_0001);
        rd_chk("kb last key", 32'hD000_0000, 32'h0000_0045);
`endif

        // LFSR reseed: zero maps to SEED; from 1 the sequence is 1, 0xB400, 0x5A00.
        wr(32'hC000_0000, 32'h0);
        rd_chk("reseed zero", 32'hC000_0000, 32'h0000_ACE1);
        wr(32'hC000_0000, 32'h1);
        rd_chk("seq 1", 32'hC000_0000, 32'h0000_0001);
        rd_chk("seq 2", 32'hC000_0000, 32'h0000_B400);
        rd_chk("seq 3", 32'hC000_0000, 32'h0000_5A00);
        wr(32'hC000_0000, 32'h1234_0000);
        rd_chk("reseed low zero", 32'hC000_0000, 32'h0000_ACE1);

        // RAM write pass-through, read-back, and reset during a read.
        bus_req = 1'b1; mem_w = 1'b1; addr_bus = 32'h0000_0010; Cpu_data2bus = 32'h0000_DEAD;
        #1;
        check("ram we", {31'b0, data_ram_we}, 32'h1);
        check("ram addr", {22'b0, ram_addr}, 32'h4);
        check("ram wdata", ram_data_in, 32'h0000_DEAD);
        @(posedge clk); #1;
        bus_req = 1'b0; mem_w = 1'b0;
        #1;
        check("ram we idle", {31'b0, data_ram_we}, 32'h0);
        rd_chk("ram readback", 32'h0000_0010, 32'h0000_DEAD);
        rd_chk("ram unwritten", 32'h0000_0014, 32'hC0DE_0005);
        bus_req = 1'b1; mem_w = 1'b0; addr_bus = 32'h0000_0010;
        #3;
        rst_n = 1'b0;
        #1;
        check("mid reset rd_valid", {31'b0, rd_valid}, 32'h0);
        check("mid reset rd_data", Cpu_data4bus, 32'h0);
        bus_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cell_idx = 4'd3;
        #1;
        check("reset clears cell3", {28'b0, cell_data}, 32'h0);
        rd_chk("reset lfsr seed", 32'hC000_0000, 32'h0000_ACE1);
        rd_chk("reset kb status", 32'hD000_0004, 32'h0);
        rd_chk("reset kb empty", 32'hD000_0000, 32'h8000_0000);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
